// File: rtl/pdm_pkg.sv
// Shared types and constants for the path delay meter.
package pdm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    LAUNCH,
    MEASURE,
    DONE,
    ABORT
  } pdmState_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pdm_sync.sv
// Multi-flop async-reset synchroniser for a single asynchronous level.
module pdm_sync
  import pdm_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic asyncIn,
  output logic syncOut
);

  logic [STAGES-1:0] syncReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) syncReg <= '0;
    else        syncReg <= {syncReg[STAGES-2:0], asyncIn};
  end

  assign syncOut = syncReg[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture controller: drives one edge into a delay chain and counts cycles until
// the synchronised chain output follows. Define PDM_ACCUM_EN for multi-run accumulation.
module path_delay_meter
  import pdm_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4095,
  parameter int SETTLE    = 8,
  parameter bit CHAIN_INV = 1'b0,
  parameter int RUNS_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       edge_sel,
  output logic                       path_input,
  input  logic                       path_result,
  output logic                       busy,
  output logic                       done,
  output logic                       timed_out,
  output logic [CNT_W-1:0]           delay_cnt,
  output logic [CNT_W+RUNS_LOG2-1:0] acc_sum
);

  if (TIMEOUT >= (64'(1) << CNT_W) || SETTLE < 1) begin : gBadParams
    $error("path_delay_meter: TIMEOUT must be below 2**CNT_W and SETTLE at least 1");
  end

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  pdmState_t        state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic             pathInReg;
  logic             timedOutReg;
  logic [CNT_W-1:0] delayCntReg;
  logic             resS;
  logic             resMatch;
  logic             lastRun;

  pdm_sync #(.STAGES(SYNC_STAGES)) uResSync (
    .clk    (clk),
    .rst_n  (rst_n),
    .asyncIn(path_result),
    .syncOut(resS)
  );

  assign resMatch = (resS == (pathInReg ^ CHAIN_INV));

`ifdef PDM_ACCUM_EN
  logic [RUNS_LOG2-1:0]       runIdx;
  logic [CNT_W+RUNS_LOG2-1:0] accReg;
  assign lastRun = (runIdx == '1);
  assign acc_sum = accReg;
`else
  assign lastRun = 1'b1;
  assign acc_sum = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = PREP;
      PREP: begin
        if (cnt >= SETTLE_LAST && resMatch) stateNext = LAUNCH;
        else if (cnt == TIMEOUT_CNT)        stateNext = ABORT;
      end
      LAUNCH:  stateNext = MEASURE;
      MEASURE: begin
        // Later accumulation runs reuse the settled final level as their baseline.
        if (resMatch)                stateNext = lastRun ? DONE : PREP;
        else if (cnt == TIMEOUT_CNT) stateNext = ABORT;
      end
      DONE:    stateNext = IDLE;
      ABORT:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pathInReg   <= 1'b0;
      timedOutReg <= 1'b0;
      delayCntReg <= '0;
`ifdef PDM_ACCUM_EN
      runIdx      <= '0;
      accReg      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          pathInReg   <= edge_sel;
          timedOutReg <= 1'b0;
          cnt         <= '0;
`ifdef PDM_ACCUM_EN
          runIdx      <= '0;
          accReg      <= '0;
`endif
        end
        PREP:   if (stateNext == PREP) cnt <= cnt + 1'b1;
        LAUNCH: begin
          pathInReg <= ~pathInReg;
          cnt       <= '0;
        end
        MEASURE: begin
          if (resMatch) begin
            delayCntReg <= cnt;
            cnt         <= '0;
`ifdef PDM_ACCUM_EN
            runIdx      <= runIdx + 1'b1;
            accReg      <= accReg + {{RUNS_LOG2{1'b0}}, cnt};
`endif
          end else if (stateNext == MEASURE) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // Result is loaded on entry to ABORT so it is valid alongside the done pulse.
      if (stateNext == ABORT && state != ABORT) begin
        timedOutReg <= 1'b1;
        delayCntReg <= TIMEOUT_CNT;
      end
    end
  end

  assign path_input = pathInReg;
  assign busy       = (state == PREP) || (state == LAUNCH) || (state == MEASURE);
  assign done       = (state == DONE) || (state == ABORT);
  assign timed_out  = timedOutReg;
  assign delay_cnt  = delayCntReg;

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter with a loopback / delay-line / stuck-level chain model.
module tb_path_delay_meter;

  localparam int CNT_W     = 16;
  localparam int TIMEOUT   = 20;
  localparam int SETTLE    = 8;
  localparam int RUNS_LOG2 = 3;
  localparam int BUDGET    = 1000;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       start = 1'b0;
  logic                       edge_sel = 1'b0;
  logic                       path_input;
  logic                       path_result;
  logic                       busy;
  logic                       done;
  logic                       timed_out;
  logic [CNT_W-1:0]           delay_cnt;
  logic [CNT_W+RUNS_LOG2-1:0] acc_sum;

  int          mode = 0;
  int          dlyK = 1;
  logic [31:0] dly = '0;
  int          nCmp = 0;
  int          nFail = 0;

`ifdef PDM_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  path_delay_meter #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .CHAIN_INV(1'b0), .RUNS_LOG2(RUNS_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .edge_sel(edge_sel),
    .path_input(path_input), .path_result(path_result), .busy(busy), .done(done),
    .timed_out(timed_out), .delay_cnt(delay_cnt), .acc_sum(acc_sum)
  );

  always #5 clk = ~clk;

  // Chain model: mode 0 loopback, 1 k-flop delay, 2 stuck low, 3 stuck high.
  always @(posedge clk) dly <= {dly[30:0], path_input};
  always_comb begin
    case (mode)
      0:       path_result = path_input;
      1:       path_result = dly[dlyK-1];
      2:       path_result = 1'b0;
      default: path_result = 1'b1;
    endcase
  end

  typedef struct {
    int   mode;
    int   k;
    logic es;
    int   expCnt;
    logic expTo;
    logic expPin;
    int   expLat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulses start, then waits for done; lat counts negedges from the accepting edge.
  task automatic runOne(input logic es, output int lat, output bit seen);
    @(negedge clk);
    edge_sel = es;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    seen = (done === 1'b1);
    if (!seen) check("done_wait_expired", 0, 1);
  endtask

  task automatic resetChecks(input string tag);
    check({tag, "_path_input"}, path_input, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timed_out"}, timed_out, 0);
    check({tag, "_delay_cnt"}, delay_cnt, 0);
    check({tag, "_acc_sum"}, acc_sum, 0);
  endtask

  initial begin
    int   lat;
    bit   seen;
    int   nDone;
    logic expPin;
    longint expAcc;

    vecs[0] = '{0, 1,  1'b0, 2,  1'b0, 1'b1, 13};
    vecs[1] = '{0, 1,  1'b1, 2,  1'b0, 1'b0, 0};
    vecs[2] = '{1, 10, 1'b1, 12, 1'b0, 1'b0, 0};
    vecs[3] = '{1, 3,  1'b0, 5,  1'b0, 1'b1, 0};
    vecs[4] = '{1, 17, 1'b0, 19, 1'b0, 1'b1, 0};
    vecs[5] = '{2, 1,  1'b0, 20, 1'b1, 1'b1, 0};
    vecs[6] = '{3, 1,  1'b0, 20, 1'b1, 1'b0, 0};
    vecs[7] = '{1, 1,  1'b1, 3,  1'b0, 1'b0, 0};

    idle(3);
    #1;
    resetChecks("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      dlyK = vecs[i].k;
      idle(40);
      runOne(vecs[i].es, lat, seen);
      if (seen) begin
        expPin = (ACCUM && !vecs[i].expTo) ? vecs[i].es : vecs[i].expPin;
        expAcc = (ACCUM && !vecs[i].expTo) ? longint'(vecs[i].expCnt) * 8 : 0;
        check($sformatf("v%0d_delay_cnt", i), delay_cnt, vecs[i].expCnt);
        check($sformatf("v%0d_timed_out", i), timed_out, vecs[i].expTo);
        check($sformatf("v%0d_path_input", i), path_input, expPin);
        check($sformatf("v%0d_busy_at_done", i), busy, 0);
        check($sformatf("v%0d_acc_sum", i), acc_sum, expAcc);
        if (!ACCUM && vecs[i].expLat != 0)
          check($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", i), done, 0);
      end
    end

    // start held high for the whole run: only the first request is accepted
    mode = 0;
    idle(10);
    nDone = 0;
    @(negedge clk);
    edge_sel = 1'b0;
    start    = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = busy;
      if (done === 1'b1) nDone++;
    end
    start = 1'b0;
    check("spam_done_count", nDone, 1);
    check("spam_delay_cnt", delay_cnt, 2);
    check("spam_timed_out", timed_out, 0);

    // reset mid-MEASURE
    mode = 1;
    dlyK = 10;
    idle(40);
    @(negedge clk);
    edge_sel = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(12);
    check("midrun_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    resetChecks("midrun");
    idle(2);
    rst_n = 1'b1;
    nDone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) nDone++;
    end
    check("midrun_no_done", nDone, 0);
    mode = 0;
    runOne(1'b0, lat, seen);
    if (seen) begin
      check("post_reset_delay_cnt", delay_cnt, 2);
      check("post_reset_timed_out", timed_out, 0);
    end

`ifdef PDM_ACCUM_EN
    // eight alternating runs through a 4-flop chain
    mode = 1;
    dlyK = 4;
    idle(40);
    runOne(1'b0, lat, seen);
    if (seen) begin
      check("accum_acc_sum", acc_sum, 48);
      check("accum_delay_cnt", delay_cnt, 6);
      check("accum_timed_out", timed_out, 0);
      check("accum_path_input", path_input, 0);
      nDone = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (done === 1'b1) nDone++;
      end
      check("accum_single_done", nDone, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
